// File: rtl/kws_wb_stream_bridge_pkg.sv
// Shared constants for the Wishbone-to-stream bridge: register map, CTRL/STATUS bit positions,
// address-window width and the internal bus-operation encoding.
package kws_wb_stream_bridge_pkg;

   localparam int WIN_W = 24;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_WDATA  = 8'h08;
   localparam logic [7:0] OFF_LDATA  = 8'h0C;
   localparam logic [7:0] OFF_RDATA  = 8'h10;

   localparam int CTRL_START    = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_FIFO_CLR = 2;

   localparam int ST_BUSY      = 0;
   localparam int ST_DONE      = 1;
   localparam int ST_W_FULL    = 2;
   localparam int ST_W_EMPTY   = 3;
   localparam int ST_L_FULL    = 4;
   localparam int ST_L_EMPTY   = 5;
   localparam int ST_R_EMPTY   = 6;
   localparam int ST_R_FULL    = 7;
   localparam int ST_W_OVF     = 8;
   localparam int ST_L_OVF     = 9;
   localparam int ST_R_OVF     = 10;
   localparam int ST_R_UDF     = 11;
   localparam int ST_START_ERR = 12;
   localparam int ST_RCNT_LSB  = 16;

   typedef enum logic [2:0] {
      OP_NONE   = 3'd0,
      OP_CTRL   = 3'd1,
      OP_STATUS = 3'd2,
      OP_WDATA  = 3'd3,
      OP_LDATA  = 3'd4,
      OP_RDATA  = 3'd5
   } op_e;

   function automatic op_e decode_off(input logic [7:0] off);
      op_e op;
      case (off)
         OFF_CTRL:   op = OP_CTRL;
         OFF_STATUS: op = OP_STATUS;
         OFF_WDATA:  op = OP_WDATA;
         OFF_LDATA:  op = OP_LDATA;
         OFF_RDATA:  op = OP_RDATA;
         default:    op = OP_NONE;
      endcase
      return op;
   endfunction

   // A same-cycle set beats a write-one-to-clear.
   function automatic logic sticky(input logic set, input logic clr, input logic q);
      return set | (q & ~clr);
   endfunction

endpackage

// File: rtl/kws_wb_stream_bridge_if.sv
// Wishbone classic slave bus between the host and the bridge.
interface kws_wb_stream_bridge_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/kws_wb_stream_bridge_sync_fifo.sv
// Single-clock FIFO with combinational head, synchronous clear and occupancy count.
// A full FIFO that pops in the same cycle still accepts a push.
module kws_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_pop_s, do_push_s;

   assign empty     = (count_q == CW'(0));
   assign full      = (count_q == CW'(DEPTH));
   assign count     = count_q;
   assign rdata     = mem_q[rd_ptr_q];
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observable once counted.
   always_ff @(posedge clk) begin
      if (do_push_s && !clr) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/kws_wb_stream_bridge.sv
// Wishbone register front-end feeding buffered weight/line streams into the CNN accelerator
// and capturing its results, with start/busy control, sticky error flags and an interrupt.
module kws_wb_stream_bridge
   import kws_wb_stream_bridge_pkg::*;
#(
   parameter int          DATA_W      = 8,
   parameter int          WFIFO_DEPTH = 16,
   parameter int          LFIFO_DEPTH = 16,
   parameter int          RFIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   kws_wb_stream_bridge_if.slave wb,
   output logic                  start,
   output logic [DATA_W-1:0]     weight_data,
   output logic                  weight_valid,
   input  logic                  weight_ready,
   output logic [DATA_W-1:0]     line_data,
   output logic                  line_valid,
   input  logic                  line_ready,
   input  logic [DATA_W-1:0]     result_data,
   input  logic                  result_valid,
   input  logic                  done,
   output logic                  irq
);

   localparam int WCW = $clog2(WFIFO_DEPTH) + 1;
   localparam int LCW = $clog2(LFIFO_DEPTH) + 1;
   localparam int RCW = $clog2(RFIFO_DEPTH) + 1;

   logic        ack_q, ack_d, we_q, we_d, rhit_q, rhit_d;
   logic [31:0] dat_q, dat_d, wdat_q, wdat_d;
   op_e         op_q, op_d, op_s;
   logic        start_q, start_d, busy_q, busy_d, irq_en_q, irq_en_d, irq_q, irq_d;
   logic        done_f_q, done_f_d, w_ovf_q, w_ovf_d, l_ovf_q, l_ovf_d;
   logic        r_ovf_q, r_ovf_d, r_udf_q, r_udf_d, serr_q, serr_d;

   logic                  req_s, wr_ctrl_s, clr_s, start_ok_s, start_bad_s, r_udf_set_s;
   logic [31:0]           w1c_s, status_s, rcnt32_s;
   logic                  w_push_s, w_pop_s, w_full_s, w_empty_s;
   logic                  l_push_s, l_pop_s, l_full_s, l_empty_s;
   logic                  r_pop_s, r_full_s, r_empty_s;
   logic [WCW-1:0]        w_count_s;
   logic [LCW-1:0]        l_count_s;
   logic [RCW-1:0]        r_count_s;
   logic [DATA_W-1:0]     r_head_s;
   logic                  unused_s;

   // A request is taken when addressed to our window; the action itself happens in the ack cycle.
   assign req_s = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q &
                  (wb.wbs_adr_i[31:32-WIN_W] == BASE_ADDR[31:32-WIN_W]);
   assign op_s  = decode_off(wb.wbs_adr_i[7:0]);

   assign wr_ctrl_s   = ack_q & we_q & (op_q == OP_CTRL);
   assign clr_s       = wr_ctrl_s & wdat_q[CTRL_FIFO_CLR];
   assign start_ok_s  = wr_ctrl_s & wdat_q[CTRL_START] & ~busy_q;
   assign start_bad_s = wr_ctrl_s & wdat_q[CTRL_START] & busy_q;
   assign w1c_s       = (ack_q & we_q & (op_q == OP_STATUS)) ? wdat_q : 32'h0000_0000;
   assign w_push_s    = ack_q & we_q & (op_q == OP_WDATA);
   assign l_push_s    = ack_q & we_q & (op_q == OP_LDATA);
   assign w_pop_s     = weight_valid & weight_ready;
   assign l_pop_s     = line_valid & line_ready;
   assign r_pop_s     = ack_q & ~we_q & (op_q == OP_RDATA) & rhit_q;
   assign r_udf_set_s = ack_q & ~we_q & (op_q == OP_RDATA) & ~rhit_q;
   assign weight_valid = ~w_empty_s;
   assign line_valid   = ~l_empty_s;
   assign rcnt32_s     = 32'(r_count_s);
   assign unused_s     = ^{wb.wbs_sel_i, wdat_q};

   kws_sync_fifo #(.W(DATA_W), .DEPTH(WFIFO_DEPTH)) u_wfifo (
      .clk(clk), .rst_n(reset_n), .clr(clr_s), .push(w_push_s), .wdata(wdat_q[DATA_W-1:0]),
      .pop(w_pop_s), .rdata(weight_data), .full(w_full_s), .empty(w_empty_s), .count(w_count_s));

   kws_sync_fifo #(.W(DATA_W), .DEPTH(LFIFO_DEPTH)) u_lfifo (
      .clk(clk), .rst_n(reset_n), .clr(clr_s), .push(l_push_s), .wdata(wdat_q[DATA_W-1:0]),
      .pop(l_pop_s), .rdata(line_data), .full(l_full_s), .empty(l_empty_s), .count(l_count_s));

   kws_sync_fifo #(.W(DATA_W), .DEPTH(RFIFO_DEPTH)) u_rfifo (
      .clk(clk), .rst_n(reset_n), .clr(clr_s), .push(result_valid), .wdata(result_data),
      .pop(r_pop_s), .rdata(r_head_s), .full(r_full_s), .empty(r_empty_s), .count(r_count_s));

   // STATUS read image.
   always_comb begin
      status_s                = 32'h0000_0000;
      status_s[ST_BUSY]       = busy_q;
      status_s[ST_DONE]       = done_f_q;
      status_s[ST_W_FULL]     = w_full_s;
      status_s[ST_W_EMPTY]    = w_empty_s;
      status_s[ST_L_FULL]     = l_full_s;
      status_s[ST_L_EMPTY]    = l_empty_s;
      status_s[ST_R_EMPTY]    = r_empty_s;
      status_s[ST_R_FULL]     = r_full_s;
      status_s[ST_W_OVF]      = w_ovf_q;
      status_s[ST_L_OVF]      = l_ovf_q;
      status_s[ST_R_OVF]      = r_ovf_q;
      status_s[ST_R_UDF]      = r_udf_q;
      status_s[ST_START_ERR]  = serr_q;
      if (rcnt32_s > 32'd255) begin
         status_s[ST_RCNT_LSB +: 8] = 8'hFF;
      end else begin
         status_s[ST_RCNT_LSB +: 8] = rcnt32_s[7:0];
      end
   end

   // Next-state for bus handshake, control and sticky flags.
   always_comb begin
      ack_d  = req_s;
      we_d   = req_s ? wb.wbs_we_i : 1'b0;
      op_d   = req_s ? op_s : OP_NONE;
      wdat_d = req_s ? wb.wbs_dat_i : wdat_q;
      rhit_d = req_s ? ~r_empty_s : 1'b0;
      dat_d  = 32'h0000_0000;
      if (req_s && !wb.wbs_we_i) begin
         case (op_s)
            OP_CTRL:   dat_d = {29'h0, 1'b0, irq_en_q, 1'b0};
            OP_STATUS: dat_d = status_s;
            OP_RDATA:  dat_d = r_empty_s ? 32'h0000_0000 : 32'(r_head_s);
            default:   dat_d = 32'h0000_0000;
         endcase
      end else begin
         dat_d = 32'h0000_0000;
      end

      start_d  = start_ok_s;
      irq_en_d = wr_ctrl_s ? wdat_q[CTRL_IRQ_EN] : irq_en_q;
      if (start_ok_s) begin
         busy_d = 1'b1;
      end else if (done) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end

      done_f_d = sticky(done, w1c_s[ST_DONE], done_f_q);
      w_ovf_d  = sticky(w_push_s & w_full_s & ~w_pop_s, w1c_s[ST_W_OVF], w_ovf_q);
      l_ovf_d  = sticky(l_push_s & l_full_s & ~l_pop_s, w1c_s[ST_L_OVF], l_ovf_q);
      r_ovf_d  = sticky(result_valid & r_full_s & ~r_pop_s, w1c_s[ST_R_OVF], r_ovf_q);
      r_udf_d  = sticky(r_udf_set_s, w1c_s[ST_R_UDF], r_udf_q);
      serr_d   = sticky(start_bad_s, w1c_s[ST_START_ERR], serr_q);
      irq_d    = irq_en_q & (done_f_q | w_ovf_q | l_ovf_q | r_ovf_q | r_udf_q | serr_q);
   end

   // Register bank.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_q    <= 1'b0;
         we_q     <= 1'b0;
         op_q     <= OP_NONE;
         wdat_q   <= 32'h0000_0000;
         rhit_q   <= 1'b0;
         dat_q    <= 32'h0000_0000;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         irq_en_q <= 1'b0;
         done_f_q <= 1'b0;
         w_ovf_q  <= 1'b0;
         l_ovf_q  <= 1'b0;
         r_ovf_q  <= 1'b0;
         r_udf_q  <= 1'b0;
         serr_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ack_q    <= ack_d;
         we_q     <= we_d;
         op_q     <= op_d;
         wdat_q   <= wdat_d;
         rhit_q   <= rhit_d;
         dat_q    <= dat_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
         irq_en_q <= irq_en_d;
         done_f_q <= done_f_d;
         w_ovf_q  <= w_ovf_d;
         l_ovf_q  <= l_ovf_d;
         r_ovf_q  <= r_ovf_d;
         r_udf_q  <= r_udf_d;
         serr_q   <= serr_d;
         irq_q    <= irq_d;
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
   assign start        = start_q;
   assign irq          = irq_q;

endmodule
